// File: rtl/game_ctrl.sv
// Game state controller: start/restart sequencing, collision detection, score and high score.
// Latency: state, score and enable update one clk after the cause is sampled; start_btn reaches the FSM on the 3rd edge.
// No backpressure: pure sampled inputs. Optional pause support is built when PAUSE_EN is defined.
module game_ctrl #(
  parameter int BIRD_X   = 100,
  parameter int BIRD_W   = 20,
  parameter int BIRD_H   = 20,
  parameter int PIPE_W   = 60,
  parameter int HOLD_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
`ifdef PAUSE_EN
  input  logic               pause_btn,
`endif
  input  logic signed [10:0] y_coord,
  input  logic        [10:0] pipe_x,
  input  logic        [10:0] gap_bot,
  input  logic        [10:0] gap_top,
  output logic        [1:0]  state,
  output logic               enable,
  output logic        [1:0]  fall_accel,
  output logic        [7:0]  score,
  output logic        [7:0]  hi_score
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  // Geometry constants widened to the 12-bit signed collision domain.
  localparam logic signed [11:0] BX = 12'(BIRD_X);
  localparam logic signed [11:0] BW = 12'(BIRD_W);
  localparam logic signed [11:0] BH = 12'(BIRD_H);
  localparam logic signed [11:0] PW = 12'(PIPE_W);

  state_t cur, nxt;

  logic [2:0]          st_sync;
  logic                start_edge;
  logic [HW-1:0]       hold_cnt;
  logic                paused;
  logic                paused_nxt;

  logic signed [11:0]  y_s, px_s, gb_s, gt_s, pr_s, prev_pr;
  logic                overlap, outside_gap, hit, hit_eff, pass;

  // Two-flop synchronizer plus delay flop; edge is one cycle per press.
  always_ff @(posedge clk) begin
    if (rst) st_sync <= '0;
    else     st_sync <= {st_sync[1:0], start_btn};
  end

  assign start_edge = st_sync[1] & ~st_sync[2];

  // Sign/zero extend everything to 12 bits so the sums below cannot wrap.
  assign y_s  = {y_coord[10], y_coord};
  assign px_s = {1'b0, pipe_x};
  assign gb_s = {1'b0, gap_bot};
  assign gt_s = {1'b0, gap_top};
  assign pr_s = px_s + PW;

  assign overlap     = (px_s <= BX + BW) && (pr_s >= BX);
  assign outside_gap = (y_s < gb_s) || (y_s + BH > gt_s);
  assign hit         = (y_s <= 12'sd0) || (overlap && outside_gap);
  assign hit_eff     = hit & ~paused;

  // Pipe right edge from the previous cycle, for detecting the crossing of the bird.
  always_ff @(posedge clk) begin
    if (rst) prev_pr <= '0;
    else     prev_pr <= pr_s;
  end

  assign pass = (pr_s < BX) && (prev_pr >= BX);

`ifdef PAUSE_EN
  logic [2:0] ps_sync;
  logic       pause_edge;

  // Pause button synchronizer, same structure as the start path.
  always_ff @(posedge clk) begin
    if (rst) ps_sync <= '0;
    else     ps_sync <= {ps_sync[1:0], pause_btn};
  end

  assign pause_edge = ps_sync[1] & ~ps_sync[2];

  // Toggle pause only while playing; leaving PLAY always unpauses.
  always_comb begin
    paused_nxt = paused;
    if (nxt != S_PLAY)                      paused_nxt = 1'b0;
    else if (cur == S_PLAY && pause_edge)   paused_nxt = ~paused;
  end

  // Pause flag register.
  always_ff @(posedge clk) begin
    if (rst) paused <= 1'b0;
    else     paused <= paused_nxt;
  end
`else
  assign paused     = 1'b0;
  assign paused_nxt = 1'b0;
`endif

  // Game state register.
  always_ff @(posedge clk) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  // Next-state decode; start presses during PLAY fall through untouched.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:  if (start_edge)                   nxt = S_READY;
      S_READY: if (start_edge)                   nxt = S_PLAY;
      S_PLAY:  if (hit_eff)                      nxt = S_OVER;
      S_OVER:  if (start_edge && hold_cnt == '0) nxt = S_READY;
      default:                                   nxt = S_IDLE;
    endcase
  end

  // Score: cleared entering READY, counts passes in PLAY unless the same cycle ends the game.
  always_ff @(posedge clk) begin
    if (rst)
      score <= 8'd0;
    else if (nxt == S_READY && cur != S_READY)
      score <= 8'd0;
    else if (cur == S_PLAY && nxt == S_PLAY && !paused && pass && score != 8'hFF)
      score <= score + 8'd1;
  end

  // High score captured at game end.
  always_ff @(posedge clk) begin
    if (rst)
      hi_score <= 8'd0;
    else if (cur == S_PLAY && nxt == S_OVER && score > hi_score)
      hi_score <= score;
  end

  // Restart lockout: counts down from entry into OVER.
  always_ff @(posedge clk) begin
    if (rst)
      hold_cnt <= '0;
    else if (cur != S_OVER && nxt == S_OVER)
      hold_cnt <= HW'(HOLD_CYC - 1);
    else if (cur == S_OVER && hold_cnt != '0)
      hold_cnt <= hold_cnt - HW'(1);
  end

  // Physics enable registered from the next state so it aligns with state.
  always_ff @(posedge clk) begin
    if (rst) enable <= 1'b0;
    else     enable <= (nxt == S_PLAY) && !paused_nxt;
  end

  assign state      = cur;
  assign fall_accel = (score[7:6] != 2'b00) ? 2'd3 : score[5:4];

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: start sequencing, scoring, collisions, restart lockout, saturation.
// Inputs change 1 time unit after the rising edge and outputs are sampled there too.
// Expected values are hand-derived from the default geometry (bird x 100..120, pipe width 60).
module tb_game_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_btn;
`ifdef PAUSE_EN
  logic               pause_btn;
`endif
  logic signed [10:0] y_coord;
  logic        [10:0] pipe_x;
  logic        [10:0] gap_bot;
  logic        [10:0] gap_top;
  logic        [1:0]  state;
  logic               enable;
  logic        [1:0]  fall_accel;
  logic        [7:0]  score;
  logic        [7:0]  hi_score;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
`ifdef PAUSE_EN
    .pause_btn  (pause_btn),
`endif
    .y_coord    (y_coord),
    .pipe_x     (pipe_x),
    .gap_bot    (gap_bot),
    .gap_top    (gap_top),
    .state      (state),
    .enable     (enable),
    .fall_accel (fall_accel),
    .score      (score),
    .hi_score   (hi_score)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 10-cycle press followed by enough idle cycles for the synchronizer to settle.
  task automatic press_start();
    start_btn = 1'b1;
    repeat (10) tick();
    start_btn = 1'b0;
    repeat (3) tick();
  endtask

  // Pipe right edge moves 100 -> 99: exactly one crossing of the bird's left side.
  task automatic pass_once();
    pipe_x = 11'd40;
    tick();
    pipe_x = 11'd39;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    start_btn = 1'b0;
`ifdef PAUSE_EN
    pause_btn = 1'b0;
`endif
    y_coord   = 11'sd150;
    pipe_x    = 11'd600;
    gap_bot   = 11'd100;
    gap_top   = 11'd200;
    repeat (3) tick();

    check("rst_state",  state,      0);
    check("rst_enable", enable,     0);
    check("rst_score",  score,      0);
    check("rst_hi",     hi_score,   0);
    check("rst_accel",  fall_accel, 0);
    rst = 1'b0;
    tick();

    // First press: IDLE -> READY on the 3rd edge after the rise.
    start_btn = 1'b1;
    tick();
    tick();
    check("idle_before_edge3", state, 0);
    tick();
    check("idle_to_ready", state, 1);
    repeat (7) tick();
    start_btn = 1'b0;
    repeat (3) tick();
    check("ready_one_per_press", state, 1);
    check("ready_enable", enable, 0);

    // Second press: READY -> PLAY, enable rises with it.
    start_btn = 1'b1;
    tick();
    tick();
    check("ready_before_edge3", state, 1);
    tick();
    check("ready_to_play", state, 2);
    check("play_enable", enable, 1);
    repeat (7) tick();
    start_btn = 1'b0;
    repeat (3) tick();

    // A press during PLAY changes nothing.
    press_start();
    check("play_ignores_start", state, 2);

    // Sweep through the gap: no hit, one pass when pipe_x goes 40 -> 39.
    for (int px = 200; px >= 0; px--) begin
      pipe_x = 11'(px);
      tick();
      if (px == 40) check("sweep_before_pass", score, 0);
      if (px == 39) check("sweep_pass", score, 1);
    end
    check("sweep_no_hit", state, 2);
    check("sweep_score", score, 1);

    // Collision with the lower pipe: bird bottom 90 below gap at 100.
    pipe_x  = 11'd90;
    y_coord = 11'sd90;
    tick();
    check("hit_state", state, 3);
    check("hit_enable", enable, 0);
    check("hit_hi", hi_score, 1);

    // Press during lockout is ignored.
    repeat (9) tick();
    press_start();
    check("over_lockout", state, 3);
    repeat (1100 - 22) tick();
    y_coord   = 11'sd150;
    pipe_x    = 11'd600;
    start_btn = 1'b1;
    tick();
    tick();
    check("over_before_edge3", state, 3);
    tick();
    check("over_to_ready", state, 1);
    check("ready_score_clr", score, 0);
    check("ready_hi_kept", hi_score, 1);
    repeat (7) tick();
    start_btn = 1'b0;
    repeat (3) tick();

    // Pass and ground hit in the same cycle: OVER with the score untouched.
    press_start();
    check("play2", state, 2);
    pass_once();
    check("play2_score", score, 1);
    pipe_x = 11'd40;
    tick();
    pipe_x  = 11'd39;
    y_coord = 11'sd0;
    tick();
    check("pass_hit_state", state, 3);
    check("pass_hit_score", score, 1);
    check("pass_hit_hi", hi_score, 1);

    // Restart and run the score to saturation.
    y_coord = 11'sd150;
    pipe_x  = 11'd600;
    repeat (1000) tick();
    press_start();
    check("ready3", state, 1);
    press_start();
    check("play3", state, 2);
    for (int i = 1; i <= 300; i++) begin
      pass_once();
      if (i == 15) check("accel_15", fall_accel, 0);
      if (i == 16) check("accel_16", fall_accel, 1);
      if (i == 16) check("score_16", score, 16);
      if (i == 48) check("accel_48", fall_accel, 3);
    end
    check("score_sat", score, 255);
    check("accel_sat", fall_accel, 3);
    check("sat_state", state, 2);
    y_coord = 11'sd0;
    tick();
    check("sat_over", state, 3);
    check("sat_hi", hi_score, 255);

`ifdef PAUSE_EN
    y_coord = 11'sd150;
    pipe_x  = 11'd600;
    repeat (1000) tick();
    press_start();
    press_start();
    check("pause_play", state, 2);
    pause_btn = 1'b1;
    repeat (3) tick();
    check("pause_enable", enable, 0);
    pause_btn = 1'b0;
    y_coord   = 11'sd0;
    repeat (5) tick();
    check("pause_no_hit", state, 2);
    check("pause_enable_hold", enable, 0);
    pause_btn = 1'b1;
    repeat (3) tick();
    check("unpause_state", state, 2);
    tick();
    check("unpause_hit", state, 3);
    pause_btn = 1'b0;
`endif

    // Reset wins over a simultaneous start press and clears the high score.
    rst       = 1'b1;
    start_btn = 1'b1;
    tick();
    check("mid_rst_state", state, 0);
    check("mid_rst_hi", hi_score, 0);
    check("mid_rst_score", score, 0);
    check("mid_rst_enable", enable, 0);
    rst       = 1'b0;
    start_btn = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter BIRD_X, default 100: fixed bird left x coordinate, pixels.
REQ-002 Parameter BIRD_W, default 20: bird width, pixels.
REQ-003 Parameter BIRD_H, default 20: bird height, pixels.
REQ-004 Parameter PIPE_W, default 60: pipe width, pixels.
REQ-005 Parameter HOLD_CYC, default 1000: number of clk cycles that OVER ignores start.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  system clock; all state updates on its rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 start_btn  in  1  asynchronous start/restart button, active-high.
REQ-010 y_coord  in  11 signed  bird bottom y; 0 = ground; y increases upward.
REQ-011 pipe_x  in  11  current pipe left x.
REQ-012 gap_bot  in  11  lower edge of pipe gap.
REQ-013 gap_top  in  11  upper edge of pipe gap.
REQ-014 state  out  2  game state: 0 IDLE, 1 READY, 2 PLAY, 3 OVER.
REQ-015 enable  out  1  physics enable; high only in PLAY (and not paused).
REQ-016 fall_accel  out  2  difficulty: min(score>>4, 3).
REQ-017 score  out  8  pipes passed this game, saturating at 255.
REQ-018 hi_score  out  8  best score since reset.

Function
REQ-019 start_btn SHALL pass through a 2-flop synchronizer plus a delay flop; start_edge = sync2 & ~sync3.
REQ-020 From a start_btn rise, start_edge SHALL assert on the 3rd sampling clk edge, for exactly one cycle per press.
REQ-021 Transitions SHALL be: IDLE -start_edge-> READY; READY -start_edge-> PLAY; PLAY -hit-> OVER; OVER -start_edge with hold_cnt==0-> READY.
REQ-022 A state change SHALL appear on state one clk after the causing condition is sampled.
REQ-023 start_edge in PLAY SHALL be ignored.
REQ-024 hit SHALL be (y_coord <= 0) OR (overlap AND outside_gap); overlap = pipe_x <= BIRD_X+BIRD_W AND pipe_x+PIPE_W >= BIRD_X; outside_gap = y_coord < gap_bot OR y_coord+BIRD_H > gap_top.
REQ-025 All hit arithmetic SHALL be 12-bit signed so no sum wraps.
REQ-026 In PLAY, when pipe_x+PIPE_W < BIRD_X and the registered previous-cycle value was >= BIRD_X, score SHALL increment by 1, saturating at 255.
REQ-027 A pass and a hit in the same cycle SHALL go to OVER without incrementing score.
REQ-028 On the PLAY->OVER transition, hi_score SHALL load score if score > hi_score.
REQ-029 On entry to OVER, hold_cnt SHALL load HOLD_CYC-1 and decrement to 0 each cycle.
REQ-030 score SHALL clear to 0 on every transition into READY.
REQ-031 enable SHALL be registered: 1 iff next state is PLAY and not paused.
REQ-032 fall_accel SHALL be combinational from score.

Reset
REQ-033 On rst: state=IDLE, enable=0, score=0, hi_score=0, fall_accel=0, hold_cnt=0, synchronizer flops=0, paused=0.
REQ-034 rst mid-game SHALL take priority over every other event in the same cycle.

Configuration
REQ-035 With PAUSE_EN defined, the block SHALL add input pause_btn (1, async, synchronized and edge-detected as REQ-019) whose edge toggles paused in PLAY only.
REQ-036 While paused: enable=0, hit and score evaluation suspended, state stays PLAY; paused clears on leaving PLAY.
REQ-037 Without PAUSE_EN, there SHALL be no pause_btn port, and paused SHALL be constant 0.

Verification
REQ-038 rst, then pulse start_btn twice (each press 10 cycles) -> state 0->1->2; each change lands 3 clk after the press; enable=1 in PLAY.
REQ-039 PLAY, y_coord=150, gap 100..200, pipe_x sweeps 200 down to 0 -> no hit; score 0->1 on the cycle pipe_x+60 drops below 100.
REQ-040 PLAY, pipe_x=90, y_coord=90, gap 100..200 -> state=3 next cycle, enable=0, hi_score=score.
REQ-041 OVER, HOLD_CYC=1000, start press at cycle 10 -> ignored; press at cycle 1100 -> READY, score=0, hi_score retained.
REQ-042 y_coord=0 in PLAY while a pass occurs in the same cycle -> OVER, score unchanged.
REQ-043 PAUSE_EN, pause press in PLAY with y_coord=0 -> enable=0, no OVER; second press -> OVER on the following cycle.
